// File: rtl/i2s_tx.sv
// i2s_tx -- I2S master transmitter.
//
// Derives SCLK and LRCK from mclk by division and serialises one stereo
// pair per frame, MSB-first, in standard I2S format: the first data bit
// of each channel lags the LRCK transition by one SCLK period. Samples
// enter through a valid/ready handshake into a one-entry holding buffer.
// At the start of every frame the held pair is promoted to the active
// pair. If nothing is held, the frame is zero and underrun pulses.
//
// Parameters
//   WIDTH  sample bits per channel
//   SLOT   SCLK periods per channel slot (WIDTH <= SLOT <= 64)
//   DIV    mclk cycles per SCLK period (even, >= 2)
//
// Ports
//   mclk       master clock, all state on posedge
//   rst        asynchronous active-high reset
//   pldin      left sample
//   prdin      right sample
//   din_valid  pldin/prdin valid
//   din_ready  holding buffer empty; transfer on din_valid && din_ready
//   sclk       bit clock (registered)
//   lrck       word select, 0 = left, 1 = right (registered)
//   sdout      serial data, changes with sclk falling (registered)
//   underrun   one-mclk pulse when a frame starts with an empty buffer
module i2s_tx #(
  parameter int WIDTH = 32,
  parameter int SLOT  = 32,
  parameter int DIV   = 4
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pldin,
  input  logic [WIDTH-1:0] prdin,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sclk,
  output logic             lrck,
  output logic             sdout,
  output logic             underrun
);

  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(2 * SLOT);

  localparam logic [DW-1:0] DMAX  = DW'(DIV - 1);
  localparam logic [DW-1:0] DHALF = DW'(DIV / 2);
  localparam logic [BW-1:0] BMAX  = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] BSLOT = BW'(SLOT);
  localparam logic [BW-1:0] BONE  = BW'(1);

  logic [DW-1:0]    dcnt;
  logic [DW-1:0]    dcnt_n;
  logic [BW-1:0]    bcnt;
  logic [BW-1:0]    bcnt_n;
  logic             fall;
  logic             load;
  logic             accept;
  logic             full;
  logic [WIDTH-1:0] hold_l;
  logic [WIDTH-1:0] hold_r;
  logic [WIDTH-1:0] act_l;
  logic [WIDTH-1:0] act_r;
  logic [WIDTH-1:0] act_l_n;
  logic [WIDTH-1:0] act_r_n;
  logic [BW-1:0]    wpos;
  logic [BW-1:0]    pos;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] msb_mask;
  logic             sbit;

  assign din_ready = ~full;

  always_comb begin
    fall     = (dcnt == DMAX);
    dcnt_n   = fall ? '0 : dcnt + 1'b1;
    bcnt_n   = (bcnt == BMAX) ? '0 : bcnt + 1'b1;
    // The frame load sits at new bcnt = 1 so that the right LSB, which
    // is sent at bcnt = 0, still comes from the previous active pair.
    load     = fall && (bcnt_n == BONE);
    accept   = din_valid && !full;

    act_l_n  = act_l;
    act_r_n  = act_r;
    if (load) begin
      if (full) begin
        act_l_n = hold_l;
        act_r_n = hold_r;
      end else begin
        act_l_n = '0;
        act_r_n = '0;
      end
    end

    // One-bit I2S delay: the bit on the wire at bcnt b belongs to
    // position b-1 of the frame. Serialise from the post-load pair so
    // the left MSB appears in the same cycle the pair is loaded.
    wpos = (bcnt_n == '0) ? BMAX : bcnt_n - 1'b1;
    if (wpos >= BSLOT) begin
      sel = act_r_n;
      pos = wpos - BSLOT;
    end else begin
      sel = act_l_n;
      pos = wpos;
    end
    // Shifting the MSB selector past the sample width yields the zero pad.
    msb_mask           = '0;
    msb_mask[WIDTH-1]  = 1'b1;
    sbit               = |(sel & (msb_mask >> pos));
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      dcnt     <= '0;
      bcnt     <= '0;
      sclk     <= 1'b0;
      lrck     <= 1'b0;
      sdout    <= 1'b0;
      underrun <= 1'b0;
      full     <= 1'b0;
      hold_l   <= '0;
      hold_r   <= '0;
      act_l    <= '0;
      act_r    <= '0;
    end else begin
      dcnt     <= dcnt_n;
      sclk     <= (dcnt_n >= DHALF);
      underrun <= 1'b0;

      if (fall) begin
        bcnt  <= bcnt_n;
        lrck  <= (bcnt_n >= BSLOT);
        sdout <= sbit;
        act_l <= act_l_n;
        act_r <= act_r_n;
        if (load) begin
          if (full) begin
            full <= 1'b0;
          end else begin
            underrun <= 1'b1;
          end
        end
      end

      // accept implies full = 0, so it never collides with the clear above.
      if (accept) begin
        hold_l <= pldin;
        hold_r <= prdin;
        full   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx -- scoreboard bench for i2s_tx (WIDTH=24, SLOT=32, DIV=4).
//
// Every accepted pair is queued with the frame index it must appear in.
// A monitor decodes sdout/lrck on sclk rising edges, rebuilds each frame
// and checks it against the queue; frames with no queued pair must be
// all-zero and carry exactly one underrun pulse at their load cycle.
module tb_i2s_tx;

  localparam int WIDTH = 24;
  localparam int SLOT  = 32;
  localparam int DIV   = 4;
  localparam int FR    = 2 * SLOT * DIV;

  logic             mclk = 1'b0;
  logic             rst  = 1'b1;
  logic [WIDTH-1:0] pldin = '0;
  logic [WIDTH-1:0] prdin = '0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic             sclk;
  logic             lrck;
  logic             sdout;
  logic             underrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int               frame;
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
  } exp_t;

  exp_t             sbq[$];
  bit               ur_seen[int];
  logic [WIDTH-1:0] acc_l = '0;
  logic [WIDTH-1:0] acc_r = '0;

  int m_n, m_w, m_k, m_p;
  bit m_rdy;

  i2s_tx #(.WIDTH(WIDTH), .SLOT(SLOT), .DIV(DIV)) dut (
    .mclk      (mclk),
    .rst       (rst),
    .pldin     (pldin),
    .prdin     (prdin),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sclk      (sclk),
    .lrck      (lrck),
    .sdout     (sdout),
    .underrun  (underrun)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp_v, cyc);
    end
  endtask

  // Frame k loads at mclk edge DIV + k*FR; a pair accepted on a load edge
  // goes to the following frame.
  function automatic int target_frame(input int e);
    return (e < DIV) ? 0 : (e - DIV) / FR + 1;
  endfunction

  // Edge counter and handshake capture (scoreboard push side).
  always @(posedge mclk or posedge rst) begin
    if (rst) begin
      cyc = 0;
      sbq.delete();
    end else begin
      cyc = cyc + 1;
      if (din_valid && din_ready) begin
        exp_t x;
        x.frame = target_frame(cyc);
        x.l     = pldin;
        x.r     = prdin;
        sbq.push_back(x);
      end
    end
  end

  task automatic frame_done(input int k);
    exp_t e;
    bit   have;
    while (sbq.size() > 0 && sbq[0].frame < k) begin
      chk("lost_pair", 64'(sbq[0].frame), 64'(k));
      void'(sbq.pop_front());
    end
    have = (sbq.size() > 0 && sbq[0].frame == k);
    if (have) begin
      e = sbq.pop_front();
    end else begin
      e.frame = k;
      e.l     = '0;
      e.r     = '0;
    end
    chk("left_sample", acc_l, e.l);
    chk("right_sample", acc_r, e.r);
    chk("underrun_frame", ur_seen.exists(k), !have);
  endtask

  // Monitor (scoreboard pop side), sampling on the falling mclk edge.
  always @(negedge mclk) begin
    if (rst) begin
      chk("rst_sclk", sclk, 0);
      chk("rst_lrck", lrck, 0);
      chk("rst_sdout", sdout, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_din_ready", din_ready, 1);
      acc_l = '0;
      acc_r = '0;
      ur_seen.delete();
    end else begin
      chk("sclk", sclk, (cyc % DIV) >= DIV / 2);
      m_rdy = 1'b1;
      foreach (sbq[i]) if (DIV + sbq[i].frame * FR > cyc) m_rdy = 1'b0;
      chk("din_ready", din_ready, m_rdy);
      if (underrun) begin
        chk("underrun_pos", (cyc >= DIV) && ((cyc - DIV) % FR == 0), 1);
        if (cyc >= DIV) ur_seen[(cyc - DIV) / FR] = 1'b1;
      end
      if ((cyc % DIV) == DIV / 2) begin
        m_n = cyc / DIV;
        chk("lrck", lrck, (m_n % (2 * SLOT)) >= SLOT);
        if (m_n == 0) begin
          chk("sdout_idle", sdout, 0);
        end else begin
          m_w = (m_n - 1) % (2 * SLOT);
          m_k = (m_n - 1) / (2 * SLOT);
          if (m_w == 0) begin
            acc_l = '0;
            acc_r = '0;
          end
          m_p = (m_w < SLOT) ? m_w : m_w - SLOT;
          if (m_p < WIDTH) begin
            if (m_w < SLOT) acc_l = {acc_l[WIDTH-2:0], sdout};
            else            acc_r = {acc_r[WIDTH-2:0], sdout};
          end else begin
            chk("pad_bit", sdout, 0);
          end
          if (m_w == 2 * SLOT - 1) frame_done(m_k);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  // with din_valid still high, so calls chain back-to-back.
  task automatic send(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    bit acc;
    bit done;
    done = 1'b0;
    pldin = l;
    prdin = r;
    din_valid = 1'b1;
    for (int t = 0; t < 2 * FR && !done; t++) begin
      acc = din_ready;
      @(negedge mclk);
      done = acc;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within %0d cycles", 2 * FR);
      din_valid = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int t = 0; t < 4 * FR && cyc < target; t++) @(negedge mclk);
    checks++;
    if (cyc < target) begin
      errors++;
      $display("FAIL wait_cyc: got cyc %0d expected %0d", cyc, target);
    end
  endtask

  initial begin
    repeat (10) @(negedge mclk);
    #2 rst = 1'b0;
    @(negedge mclk);

    // Frame 0: pair accepted right after reset.
    send(24'hA50F3C, 24'h5AF0C3);
    din_valid = 1'b0;

    // Frame 1 left empty, then four pairs streamed with valid held high.
    wait_cyc(300);
    send(24'h123456, 24'hFEDCBA);
    send(24'h800001, 24'h7FFFFE);
    send(24'hFFFFFF, 24'h000000);
    send(24'h0F0F0F, 24'hC0FFEE);
    din_valid = 1'b0;

    // Frame 6 empty; handshake lands exactly on the frame 7 load edge.
    wait_cyc(DIV + 7 * FR - 1);
    send(24'hDEADBE, 24'h654321);
    din_valid = 1'b0;

    // Fill the buffer for frame 9, then reset mid right slot of frame 8.
    wait_cyc(DIV + 8 * FR + 8);
    send(24'h111111, 24'h222222);
    din_valid = 1'b0;
    wait_cyc((8 * 2 * SLOT + 40) * DIV + DIV / 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sclk", sclk, 0);
    chk("async_rst_lrck", lrck, 0);
    chk("async_rst_sdout", sdout, 0);
    chk("async_rst_din_ready", din_ready, 1);
    repeat (3) @(negedge mclk);
    #2 rst = 1'b0;
    @(negedge mclk);

    // Clean restart: frame 0 carries the new pair, frame 1 is empty.
    send(24'h3C3C3C, 24'hA1B2C3);
    din_valid = 1'b0;
    wait_cyc(2 * FR + 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
